toggle_count_reader: RTL

TOGGLE_COUNT_READER -- requirements
Module: toggle_count_reader

---
 rtl/pwr_pkg.sv | 24 ++
 rtl/toggle_ctr.sv | 65 ++++++
 rtl/toggle_count_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pwr_pkg.sv
// Shared definitions for the toggle-count reader: default sizes, the read
// FSM state encoding, and a helper for sizing the channel index.
package pwr_pkg;

  // Default number of monitored nets (BUF, NOT, NAND, NOR cell outputs).
  localparam int DEF_NCH = 4;

  // Default toggle counter width.
  localparam int DEF_CW = 16;

  // Read FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACK     = 2'd2
  } rd_state_e;

  // Width of a channel index; never below 1 bit so the port stays legal
  // for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/toggle_ctr.sv
// One monitored channel: registers the net, detects any transition
// (rising or falling) and counts it into a saturating counter with a
// sticky saturation flag. A clear from the read path wins over the old
// value but still keeps a same-cycle toggle, so no event is lost.
module toggle_ctr #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          t,      // monitored cell output
  input  logic          v,      // t_q holds a real sample
  input  logic          en,     // counting enable
  input  logic          clr,    // clear counter and sat flag this edge
  output logic [CW-1:0] cnt,
  output logic          sat
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          t_q;
  logic          t_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          sat_q;
  logic          sat_d;
  logic          toggle;

  // Edge detect and next counter / flag value.
  always_comb begin
    t_d    = t;
    toggle = v && en && (t != t_q);
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (clr) begin
      // The counter restarts from this cycle's event, if any.
      cnt_d = toggle ? CNT_ONE : '0;
      sat_d = 1'b0;
    end else if (toggle) begin
      if (cnt_q == CNT_MAX) begin
        // Hold at full scale and remember that events were dropped.
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q   <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/toggle_count_reader.sv
// Toggle-count reader: NCH independent saturating toggle counters plus a
// four-phase read port. A read latches the channel index, captures the
// counter (value before this cycle's increment) and its sat flag, then
// raises RD_ACK until the requester drops RD_REQ.
//
// Handshake: RD_REQ is a level. RD_REQ=1 sampled in IDLE starts a read and
// latches RD_IDX; RD_ACK rises two edges later together with stable
// RD_DATA/RD_SAT and stays high until RD_REQ is sampled 0, at which edge
// RD_ACK falls and the port returns to IDLE. The requester must hold
// RD_REQ high until it sees RD_ACK. BUSY covers CAPTURE and ACK.
module toggle_count_reader
  import pwr_pkg::*;
#(
  parameter  int NCH       = DEF_NCH,
  parameter  int CW        = DEF_CW,
  parameter  int CLR_ON_RD = 1,
  localparam int IW        = idx_width(NCH)
) (
  input  logic           C,
  input  logic           R,
  input  logic [NCH-1:0] T,
  input  logic           EN,
  input  logic           RD_REQ,
  input  logic [IW-1:0]  RD_IDX,
  output logic           RD_ACK,
  output logic [CW-1:0]  RD_DATA,
  output logic           RD_SAT,
  output logic           BUSY,
  output logic [1:0]     dbg_state
);

  // Sample-valid flag shared by all channels.
  logic           v_q;
  logic           v_d;

  // Read FSM and its registered outputs.
  rd_state_e      state_q;
  rd_state_e      state_d;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  idx_d;
  logic [CW-1:0]  data_q;
  logic [CW-1:0]  data_d;
  logic           sat_q;
  logic           sat_d;
  logic           ack_q;
  logic           ack_d;
  logic           busy_q;
  logic           busy_d;

  // Per-channel counter outputs and clear strobes.
  logic [CW-1:0]  cnt_arr [NCH];
  logic [NCH-1:0] sat_vec;
  logic [NCH-1:0] clr_vec;

  // Addressed channel view; zero when the latched index is out of range.
  logic [CW-1:0]  sel_cnt;
  logic           sel_sat;

  // The first edge after reset only loads the sample registers.
  always_comb begin
    v_d = 1'b1;
  end

  // Valid flag register.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

  // Counter bank: one edge detector and saturating counter per channel.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    toggle_ctr #(
      .CW (CW)
    ) u_ctr (
      .clk   (C),
      .rst_n (R),
      .t     (T[g]),
      .v     (v_q),
      .en    (EN),
      .clr   (clr_vec[g]),
      .cnt   (cnt_arr[g]),
      .sat   (sat_vec[g])
    );
  end

  // Select the addressed channel and generate its clear during CAPTURE.
  // An index with no matching channel selects nothing and clears nothing.
  always_comb begin
    sel_cnt = '0;
    sel_sat = 1'b0;
    clr_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(idx_q) == i) begin
        sel_cnt    = cnt_arr[i];
        sel_sat    = sat_vec[i];
        clr_vec[i] = (CLR_ON_RD != 0) && (state_q == ST_CAPTURE);
      end
    end
  end

  // Read FSM next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    sat_d   = sat_q;
    ack_d   = ack_q;
    case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (RD_REQ) begin
          // The index is taken only here; later changes are ignored.
          idx_d   = RD_IDX;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Counter outputs still show the value before this edge's update.
        data_d  = sel_cnt;
        sat_d   = sel_sat;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (RD_REQ) begin
          ack_d = 1'b1;
        end else begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Read FSM state and registered outputs.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign RD_ACK    = ack_q;
  assign RD_DATA   = data_q;
  assign RD_SAT    = sat_q;
  assign BUSY      = busy_q;
  assign dbg_state = state_q;

endmodule
